// File: rtl/sdram_multiport_bridge_if.sv
// sdram_multiport_bridge_if: access bus between the multiport bridge and the SDRAM controller
interface sdram_multiport_bridge_if;
    logic [24:0] access_address;
    logic [9:0]  access_num;
    logic [15:0] access_data_in;
    logic        write_request;
    logic        read_request;
    logic        enable_refresh;
    logic        sdram_ldqm;
    logic        sdram_udqm;
    logic [15:0] access_data_out;
    logic        write_flag;
    logic        read_flag;
    logic        idle;
    logic        refresh_mode;
    modport master (
        output access_address, access_num, access_data_in, write_request, read_request,
               enable_refresh, sdram_ldqm, sdram_udqm,
        input  access_data_out, write_flag, read_flag, idle, refresh_mode
    );
    modport slave (
        input  access_address, access_num, access_data_in, write_request, read_request,
               enable_refresh, sdram_ldqm, sdram_udqm,
        output access_data_out, write_flag, read_flag, idle, refresh_mode
    );
endinterface

// File: rtl/sdram_multiport_bridge.sv
// sdram_multiport_bridge: round-robin arbiter putting NUM_CH word requesters onto one SDRAM controller port
module sdram_multiport_bridge #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 22,
    parameter int REFRESH_MAX = 1024
) (
    input  logic                           sdram_clock,
    input  logic                           sdram_reset,
    input  logic [NUM_CH-1:0]              ch_req,
    input  logic [NUM_CH-1:0]              ch_we,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH-1:0][15:0]        ch_wdata,
    input  logic [NUM_CH-1:0][1:0]         ch_be,
    output logic [NUM_CH-1:0]              ch_ack,
    output logic [15:0]                    ch_rdata,
    input  logic                           no_command_state,
    sdram_multiport_bridge_if.master       bus
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int RW = $clog2(REFRESH_MAX + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     grant_q, grant_d, pick;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]        be_q, be_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [2:0]        sync_q, sync_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              refresh_q, refresh_d;
    logic              busy, flag, req_held;

    assign busy     = state_q == S_ISSUE || state_q == S_XFER;
    assign flag     = we_q ? bus.write_flag : bus.read_flag;
    assign req_held = ch_req[grant_q];

    // next requester after the last granted one, wrapping; farther channels are overridden by nearer ones
    always_comb begin
        pick = grant_q;
        for (int i = NUM_CH; i >= 1; i--)
            if (ch_req[CW'((int'(grant_q) + i) % NUM_CH)]) pick = CW'((int'(grant_q) + i) % NUM_CH);
    end

    // access FSM: grant and latch, hand to the controller, then ack or abort
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE:
                if (bus.idle && !bus.refresh_mode && |ch_req) begin
                    grant_d = pick;
                    addr_d  = ch_addr[pick];
                    we_d    = ch_we[pick];
                    wdata_d = ch_wdata[pick];
                    be_d    = ch_be[pick];
                    state_d = (ch_we[pick] && ch_be[pick] == 2'b00) ? S_DONE : S_ISSUE;
                end
            S_ISSUE: state_d = !req_held ? S_ABORT : flag ? S_XFER : S_ISSUE;
            S_XFER:  state_d = !req_held ? S_ABORT : !flag ? S_DONE : S_XFER;
            S_DONE:  state_d = req_held ? S_DONE : S_IDLE;
            S_ABORT: state_d = bus.idle ? S_IDLE : S_ABORT;
            default: state_d = S_IDLE;
        endcase
        if (busy && !we_q && bus.read_flag) rdata_d = bus.access_data_out;
        ack_d = (state_d == S_DONE && state_q != S_DONE) ? NUM_CH'(1) << grant_d : '0;
    end

    // refresh: one pulse per synchronized rising edge or counter expiry, merged when both coincide
    always_comb begin
        sync_d    = {sync_q[1:0], no_command_state};
        refresh_d = (sync_q[1] && !sync_q[2]) || rcnt_q == RW'(REFRESH_MAX - 1);
        rcnt_d    = refresh_d ? '0 : rcnt_q + RW'(1);
    end

    // state registers; the pointer starts at the last channel so channel 0 wins first
    always_ff @(posedge sdram_clock or posedge sdram_reset) begin
        if (sdram_reset) begin
            state_q   <= S_IDLE;
            grant_q   <= CW'(NUM_CH - 1);
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
            sync_q    <= '0;
            rcnt_q    <= '0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            sync_q    <= sync_d;
            rcnt_q    <= rcnt_d;
            refresh_q <= refresh_d;
        end
    end

    assign ch_ack             = ack_q;
    assign ch_rdata           = rdata_q;
    assign bus.access_num     = state_q != S_IDLE ? 10'd1 : 10'd0;
    assign bus.access_address = busy ? 25'(addr_q) : '0;
    assign bus.access_data_in = busy && we_q ? wdata_q : '0;
    assign bus.write_request  = state_q == S_ISSUE && we_q;
    assign bus.read_request   = state_q == S_ISSUE && !we_q;
    assign bus.enable_refresh = refresh_q;
    assign bus.sdram_ldqm     = state_q == S_ABORT || (busy && we_q && !be_q[0]);
    assign bus.sdram_udqm     = state_q == S_ABORT || (busy && we_q && !be_q[1]);
endmodule

// File: tb/tb_sdram_multiport_bridge.sv
// tb_sdram_multiport_bridge: directed and randomized checks of the bridge against a small arbitration model
module tb_sdram_multiport_bridge;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       ch_req, ch_we, ch_ack;
    logic [1:0][21:0] ch_addr;
    logic [1:0][15:0] ch_wdata;
    logic [1:0][1:0]  ch_be;
    logic [15:0]      ch_rdata;
    logic             nc;
    int               checks = 0;
    int               errors = 0;

    sdram_multiport_bridge_if bus ();

    sdram_multiport_bridge #(.NUM_CH(2), .ADDR_W(22), .REFRESH_MAX(16)) dut (
        .sdram_clock(clk), .sdram_reset(rst), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_be(ch_be), .ch_ack(ch_ack), .ch_rdata(ch_rdata),
        .no_command_state(nc), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.enable_refresh && n < 40);
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (!(bus.read_request || bus.write_request) && n < 20) begin
            tick();
            n++;
        end
    endtask

    // arbitration model: a lone requester wins; with both pending the one not served last wins
    function automatic int rr_pick(input int mask, input int prev);
        return mask == 3 ? 1 - prev : (mask == 1 ? 0 : 1);
    endfunction

    task automatic start(input int c, input logic we, input logic [21:0] a, input logic [15:0] wd, input logic [1:0] be);
        ch_we[c]    = we;
        ch_addr[c]  = a;
        ch_wdata[c] = wd;
        ch_be[c]    = be;
        ch_req[c]   = 1'b1;
    endtask

    // plays the controller for one access of channel c and checks the requester-visible result
    task automatic serve(input int c, input logic [15:0] rd, input int lat, input int len);
        int n;
        logic we;
        logic [1:0] dqm;
        we  = ch_we[c];
        dqm = we ? 2'(~ch_be[c]) : 2'b00;
        if (we && ch_be[c] == 2'b00) begin
            tick();
            chk("skip_ack", 32'(ch_ack), 32'(1 << c));
            chk("skip_noreq", 32'({bus.write_request, bus.read_request}), 0);
            chk("skip_num", 32'(bus.access_num), 1);
        end else begin
            wait_issue(n);
            chk("req_latency", n, 1);
            chk("req_type", 32'({bus.write_request, bus.read_request}), we ? 2 : 1);
            chk("issue_addr", 32'(bus.access_address), 32'(ch_addr[c]));
            chk("issue_dqm", 32'({bus.sdram_udqm, bus.sdram_ldqm}), 32'(dqm));
            chk("issue_num", 32'(bus.access_num), 1);
            if (we) chk("issue_wdata", 32'(bus.access_data_in), 32'(ch_wdata[c]));
            repeat (lat) tick();
            for (int k = 0; k < len; k++) begin
                if (we) bus.write_flag = 1'b1;
                else begin
                    bus.read_flag = 1'b1;
                    bus.access_data_out = (k == len - 1) ? rd : 16'($urandom);
                end
                tick();
                chk("xfer_addr", 32'(bus.access_address), 32'(ch_addr[c]));
                chk("xfer_dqm", 32'({bus.sdram_udqm, bus.sdram_ldqm}), 32'(dqm));
                chk("xfer_noack", 32'(ch_ack), 0);
            end
            bus.write_flag = 1'b0;
            bus.read_flag = 1'b0;
            bus.access_data_out = 16'($urandom);
            tick();
            chk("ack", 32'(ch_ack), 32'(1 << c));
            chk("done_num", 32'(bus.access_num), 1);
        end
        if (!we) chk("rdata_ack", 32'(ch_rdata), 32'(rd));
        ch_req[c] = 1'b0;
        tick();
        chk("ack_once", 32'(ch_ack), 0);
        if (!we) chk("rdata_hold", 32'(ch_rdata), 32'(rd));
    endtask

    initial begin
        int n, mask, w, last;
        logic [15:0] rdv [2];
        int latv [2];
        int lenv [2];
        rst = 1'b1;
        ch_req = '0;
        ch_we = '0;
        ch_addr = '0;
        ch_wdata = '0;
        ch_be = '0;
        nc = 1'b0;
        bus.access_data_out = '0;
        bus.write_flag = 1'b0;
        bus.read_flag = 1'b0;
        bus.idle = 1'b1;
        bus.refresh_mode = 1'b0;
        last = 1;
        tick();
        tick();
        chk("rst_ack", 32'(ch_ack), 0);
        chk("rst_rdata", 32'(ch_rdata), 0);
        chk("rst_num", 32'(bus.access_num), 0);
        chk("rst_addr", 32'(bus.access_address), 0);
        chk("rst_ctl", 32'({bus.write_request, bus.read_request, bus.enable_refresh, bus.sdram_ldqm, bus.sdram_udqm}), 0);
        rst = 1'b0;
        wait_pulse(n);
        chk("refresh_first", n, 16);
        wait_pulse(n);
        chk("refresh_period", n, 16);
        repeat (4) tick();
        nc = 1'b1;
        wait_pulse(n);
        chk("refresh_edge", n, 3);
        wait_pulse(n);
        chk("refresh_restart", n, 16);
        nc = 1'b0;
        repeat (13) tick();
        nc = 1'b1;
        wait_pulse(n);
        chk("refresh_coincide", n, 3);
        tick();
        chk("refresh_single", 32'(bus.enable_refresh), 0);
        wait_pulse(n);
        chk("refresh_after_merge", n, 15);
        start(0, 1'b0, 22'h000AA0, 16'h0, 2'b11);
        start(1, 1'b0, 22'h000BB0, 16'h0, 2'b11);
        serve(0, 16'h1111, 0, 1);
        serve(1, 16'h2222, 1, 2);
        start(0, 1'b1, 22'h000123, 16'hA55A, 2'b01);
        serve(0, 16'h0, 1, 1);
        start(0, 1'b1, 22'h000CC0, 16'h1234, 2'b11);
        start(1, 1'b1, 22'h000DD0, 16'h5678, 2'b10);
        serve(1, 16'h0, 0, 1);
        serve(0, 16'h0, 0, 1);
        start(0, 1'b0, 22'h3FFFFF, 16'h0, 2'b11);
        serve(0, 16'h3C3C, 2, 2);
        bus.refresh_mode = 1'b1;
        start(1, 1'b0, 22'h000042, 16'h0, 2'b11);
        repeat (3) tick();
        chk("refresh_mode_hold", 32'({bus.access_num, bus.read_request}), 0);
        bus.refresh_mode = 1'b0;
        serve(1, 16'hBEEF, 0, 1);
        start(1, 1'b0, 22'h000077, 16'h0, 2'b11);
        wait_issue(n);
        chk("abort_issue", n, 1);
        bus.read_flag = 1'b1;
        bus.access_data_out = 16'h9999;
        tick();
        bus.idle = 1'b0;
        ch_req[1] = 1'b0;
        tick();
        chk("abort_dqm", 32'({bus.sdram_udqm, bus.sdram_ldqm}), 3);
        chk("abort_num", 32'(bus.access_num), 1);
        chk("abort_noack", 32'(ch_ack), 0);
        bus.read_flag = 1'b0;
        repeat (2) tick();
        chk("abort_wait_dqm", 32'({bus.sdram_udqm, bus.sdram_ldqm}), 3);
        chk("abort_wait_noack", 32'(ch_ack), 0);
        bus.idle = 1'b1;
        tick();
        chk("abort_idle", 32'({bus.access_num, bus.sdram_udqm, bus.sdram_ldqm}), 0);
        chk("abort_idle_noack", 32'(ch_ack), 0);
        start(0, 1'b1, 22'h000555, 16'hFFFF, 2'b00);
        serve(0, 16'h0, 0, 1);
        last = 0;
        for (int t = 0; t < 24; t++) begin
            mask = $urandom_range(1, 3);
            for (int c = 0; c < 2; c++) begin
                ch_we[c] = 1'($urandom);
                ch_addr[c] = 22'($urandom);
                ch_wdata[c] = 16'($urandom);
                ch_be[c] = 2'($urandom);
                rdv[c] = 16'($urandom);
                latv[c] = $urandom_range(0, 2);
                lenv[c] = $urandom_range(1, 3);
            end
            ch_req = 2'(mask);
            w = rr_pick(mask, last);
            serve(w, rdv[w], latv[w], lenv[w]);
            last = w;
            if (mask == 3) begin
                w = 1 - w;
                serve(w, rdv[w], latv[w], lenv[w]);
                last = w;
            end
        end
        start(0, 1'b1, 22'h000321, 16'hCAFE, 2'b11);
        wait_issue(n);
        chk("midrst_issue", n, 1);
        bus.write_flag = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_out", 32'({bus.access_num, bus.write_request, bus.sdram_ldqm, bus.sdram_udqm, ch_ack}), 0);
        chk("midrst_addr", 32'(bus.access_address), 0);
        ch_req = '0;
        bus.write_flag = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_noack", 32'(ch_ack), 0);
        end
        chk("midrst_rdata", 32'(ch_rdata), 0);
        last = 1;
        start(0, 1'b0, 22'h000101, 16'h0, 2'b11);
        start(1, 1'b0, 22'h000202, 16'h0, 2'b11);
        w = rr_pick(3, last);
        serve(w, 16'h7E7E, 0, 1);
        serve(1 - w, 16'h8181, 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
